// File: rtl/seq_mul_pkg.sv
// Shared state encoding and counter sizing for the shift-add multiplier.
package seq_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int cnt_width(input int w);
      return $clog2(w);
   endfunction

endpackage

// File: rtl/seq_mul_adder.sv
// W-bit adder with carry-out for the multiplier's accumulate step.
module seq_mul_adder #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier, one multiplier bit per cycle, full 2W-bit product.
// Define MUL_SIGNED_EN to add the signed_mode port and two's-complement support.
module seq_multiplier
   import seq_mul_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
`ifdef MUL_SIGNED_EN
   input  logic         signed_mode,
`endif
   output logic         ready,
   output logic         done,
   output logic [W-1:0] R1,
   output logic [W-1:0] R2,
   output logic         Overflow,
   output state_t       state_dbg
);

   // Handshake: a request is accepted on a rising edge where start=1 and ready=1;
   // ready is high only in IDLE, and done pulses for the single cycle the result appears.
   localparam int CW = cnt_width(W);

   state_t          state, state_next;
   logic [CW-1:0]   count;
   logic [W-1:0]    a_reg, b_reg;
   logic [W-1:0]    a_in, b_in;
   logic [2*W:0]    acc, acc_step, acc_shift;
   logic [W-1:0]    sum;
   logic            cout;
   logic [2*W-1:0]  prod;
   logic            ovf;
   logic            last;

`ifdef MUL_SIGNED_EN
   logic neg_reg, sgn_reg;
   logic sign_a, sign_b;

   // Magnitudes go in; the most negative value maps naturally to 2^(W-1).
   assign sign_a = signed_mode & A[W-1];
   assign sign_b = signed_mode & B[W-1];
   assign a_in   = sign_a ? -A : A;
   assign b_in   = sign_b ? -B : B;
`else
   assign a_in = A;
   assign b_in = B;
`endif

   seq_mul_adder #(.W(W)) u_adder (
      .a   (acc[2*W-1:W]),
      .b   (a_reg),
      .sum (sum),
      .cout(cout)
   );

   assign last = (count == CW'(W - 1));

   always_comb begin
      acc_step  = b_reg[count] ? {cout, sum, acc[W-1:0]} : acc;
      acc_shift = acc_step >> 1;
      prod      = acc_shift[2*W-1:0];
      ovf       = (prod[2*W-1:W] != '0);
`ifdef MUL_SIGNED_EN
      if (neg_reg)
         prod = -acc_shift[2*W-1:0];
      if (sgn_reg)
         ovf = (prod[2*W-1:W] != {W{prod[W-1]}});
      else
         ovf = (prod[2*W-1:W] != '0);
`endif
   end

   always_comb begin
      state_next = state;
      ready      = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start)
               state_next = RUN;
         end
         RUN: begin
            if (last)
               state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign state_dbg = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         count    <= '0;
         a_reg    <= '0;
         b_reg    <= '0;
         acc      <= '0;
         R1       <= '0;
         R2       <= '0;
         Overflow <= 1'b0;
`ifdef MUL_SIGNED_EN
         neg_reg  <= 1'b0;
         sgn_reg  <= 1'b0;
`endif
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg <= a_in;
                  b_reg <= b_in;
                  acc   <= '0;
                  count <= '0;
`ifdef MUL_SIGNED_EN
                  neg_reg <= sign_a ^ sign_b;
                  sgn_reg <= signed_mode;
`endif
               end
            end
            RUN: begin
               acc   <= acc_shift;
               count <= count + CW'(1);
               // Results land on the final RUN edge so they are valid while done is high.
               if (last) begin
                  R1       <= prod[W-1:0];
                  R2       <= prod[2*W-1:W];
                  Overflow <= ovf;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at W=3 (signed cases need MUL_SIGNED_EN).
module tb_seq_multiplier;
   import seq_mul_pkg::*;

   localparam int W = 3;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] A, B;
   logic         mode;
   logic         ready, done, Overflow;
   logic [W-1:0] R1, R2;
   state_t       state_dbg;

   int checks = 0;
   int errors = 0;
   logic [2*W:0] exp_q[$];

   seq_multiplier #(.W(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .A          (A),
      .B          (B),
`ifdef MUL_SIGNED_EN
      .signed_mode(mode),
`endif
      .ready      (ready),
      .done       (done),
      .R1         (R1),
      .R2         (R2),
      .Overflow   (Overflow),
      .state_dbg  (state_dbg)
   );

   always #5 clk = ~clk;

   // Reference: {overflow, product[2W-1:0]} from plain integer arithmetic.
   function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
      int ia, ib, p;
      logic [2*W-1:0] pt;
      logic o;
      ia = (s && a[W-1]) ? int'(a) - (1 << W) : int'(a);
      ib = (s && b[W-1]) ? int'(b) - (1 << W) : int'(b);
      p  = ia * ib;
      pt = p[2*W-1:0];
      if (s)
         o = (p < -(1 << (W-1))) || (p > (1 << (W-1)) - 1);
      else
         o = (p >= (1 << W));
      return {o, pt};
   endfunction

   // Drives one request and waits for done; lat counts edges from start assertion.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
      A = a;
      B = b;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      while (!done && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      A = '0;
      B = '0;
      mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_handshake: ready=%b done=%b, expected ready=1 done=0", ready, done);
      end
      checks++;
      if (R1 !== '0 || R2 !== '0 || Overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: R1=%0d R2=%0d ovf=%b, expected 0 0 0", R1, R2, Overflow);
      end
      checks++;
      if (state_dbg !== IDLE) begin
         errors++;
         $display("FAIL reset_state: state=%0d, expected %0d", state_dbg, IDLE);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_unsigned();
      logic [W-1:0] va[3] = '{3'd2, 3'd3, 3'd7};
      logic [W-1:0] vb[3] = '{3'd3, 3'd4, 3'd7};
      logic [W-1:0] e1[3] = '{3'd6, 3'd4, 3'd1};
      logic [W-1:0] e2[3] = '{3'd0, 3'd1, 3'd6};
      logic         eo[3] = '{1'b0, 1'b1, 1'b1};
      int lat;
      mode = 1'b0;
      for (int i = 0; i < 3; i++) begin
         do_op(va[i], vb[i], lat);
         checks++;
         if (lat !== W + 1) begin
            errors++;
            $display("FAIL unsigned_latency[%0d]: got %0d cycles, expected %0d", i, lat, W + 1);
         end
         checks++;
         if (R1 !== e1[i] || R2 !== e2[i] || Overflow !== eo[i]) begin
            errors++;
            $display("FAIL unsigned_result[%0d]: R1=%0d R2=%0d ovf=%b, expected %0d %0d %b",
                     i, R1, R2, Overflow, e1[i], e2[i], eo[i]);
         end
         @(posedge clk); #1;
         checks++;
         if (ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL unsigned_ready_return[%0d]: ready=%b done=%b, expected 1 0", i, ready, done);
         end
      end
   endtask

`ifdef MUL_SIGNED_EN
   task automatic test_signed();
      logic [W-1:0] va[2] = '{3'd7, 3'd4};
      logic [W-1:0] vb[2] = '{3'd7, 3'd7};
      logic [W-1:0] e1[2] = '{3'd1, 3'd4};
      logic [W-1:0] e2[2] = '{3'd0, 3'd0};
      logic         eo[2] = '{1'b0, 1'b1};
      int lat;
      mode = 1'b1;
      for (int i = 0; i < 2; i++) begin
         do_op(va[i], vb[i], lat);
         checks++;
         if (lat !== W + 1 || R1 !== e1[i] || R2 !== e2[i] || Overflow !== eo[i]) begin
            errors++;
            $display("FAIL signed_result[%0d]: lat=%0d R1=%0d R2=%0d ovf=%b, expected %0d %0d %0d %b",
                     i, lat, R1, R2, Overflow, W + 1, e1[i], e2[i], eo[i]);
         end
         @(posedge clk); #1;
      end
      mode = 1'b0;
   endtask
`endif

   task automatic test_busy_guard();
      int n_done = 0;
      logic [W-1:0] r1 = '0, r2 = '0;
      mode = 1'b0;
      A = 3'd3;
      B = 3'd7;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      A = 3'd1;
      B = 3'd1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (done) begin
            n_done++;
            r1 = R1;
            r2 = R2;
         end
      end
      checks++;
      if (n_done !== 1) begin
         errors++;
         $display("FAIL busy_done_count: got %0d pulses, expected 1", n_done);
      end
      checks++;
      if (r1 !== 3'd5 || r2 !== 3'd2) begin
         errors++;
         $display("FAIL busy_result: R1=%0d R2=%0d, expected 5 2", r1, r2);
      end
   endtask

   task automatic test_reset_mid_run();
      int lat;
      mode = 1'b0;
      A = 3'd7;
      B = 3'd7;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if (R1 !== '0 || R2 !== '0 || Overflow !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
         errors++;
         $display("FAIL midrun_reset: R1=%0d R2=%0d ovf=%b done=%b ready=%b, expected 0 0 0 0 1",
                  R1, R2, Overflow, done, ready);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      do_op(3'd2, 3'd2, lat);
      checks++;
      if (lat !== W + 1 || R1 !== 3'd4 || R2 !== 3'd0 || Overflow !== 1'b0) begin
         errors++;
         $display("FAIL after_reset_op: lat=%0d R1=%0d R2=%0d ovf=%b, expected %0d 4 0 0",
                  lat, R1, R2, Overflow, W + 1);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int cyc = 0, last_cyc = -1, n_done = 0;
      logic [2*W:0] e;
      mode = 1'b0;
      A = 3'd5;
      B = 3'd6;
      e = model(A, B, 1'b0);
      start = 1'b1;
      while (n_done < 3 && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
         if (done) begin
            n_done++;
            checks++;
            if ({Overflow, R2, R1} !== e) begin
               errors++;
               $display("FAIL b2b_result[%0d]: got %b, expected %b", n_done, {Overflow, R2, R1}, e);
            end
            if (last_cyc >= 0) begin
               checks++;
               if (cyc - last_cyc !== W + 2) begin
                  errors++;
                  $display("FAIL b2b_spacing[%0d]: got %0d cycles, expected %0d",
                           n_done, cyc - last_cyc, W + 2);
               end
            end
            last_cyc = cyc;
         end
      end
      start = 1'b0;
      checks++;
      if (n_done !== 3) begin
         errors++;
         $display("FAIL b2b_count: got %0d results, expected 3", n_done);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic [W-1:0] a, b;
      logic [2*W:0] e;
      int lat;
      for (int i = 0; i < 40; i++) begin
         a = W'($urandom_range(0, (1 << W) - 1));
         b = W'($urandom_range(0, (1 << W) - 1));
`ifdef MUL_SIGNED_EN
         mode = 1'($urandom_range(0, 1));
`else
         mode = 1'b0;
`endif
         exp_q.push_back(model(a, b, mode));
         do_op(a, b, lat);
         e = exp_q.pop_front();
         checks++;
         if (lat !== W + 1 || {Overflow, R2, R1} !== e) begin
            errors++;
            $display("FAIL random[%0d]: a=%0d b=%0d s=%b lat=%0d got %b, expected %b lat %0d",
                     i, a, b, mode, lat, {Overflow, R2, R1}, e, W + 1);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
`ifdef MUL_SIGNED_EN
      test_signed();
`endif
      test_busy_guard();
      test_reset_mid_run();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

- Parametrised multi-cycle shift-add multiplier for the ALU.
- Produces the full 2W-bit product as a low half (R1) and a high half (R2), plus an Overflow flag for the W-bit truncated result.
- Uses a start/ready/done handshake and processes one multiplier bit per cycle, trading latency for area.
- Signed operation is optional at compile time.

## Interface
- W, 16: operand width and width of each result half; legal values 2..32.
- clk  in  1: single clock; all state updates on the rising edge.
- reset  in  1: asynchronous, active-high; clears all state.
- start  in  1: request a multiply; accepted only when ready=1.
- A  in  W: multiplicand; sampled on the accepted start.
- B  in  W: multiplier; sampled on the accepted start.
- signed_mode  in  1: present only with MUL_SIGNED_EN. 1 means two's-complement operands. Sampled on the accepted start.
- ready  out  1: high only in IDLE.
- done  out  1: one-cycle pulse when the result becomes valid.
- R1  out  W: product bits [W-1:0].
- R2  out  W: product bits [2W-1:W].
- Overflow  out  1: the product is not representable in W bits (see Operation).

## Operation
- States:
  - IDLE: ready=1. On start, latch A, B and signed_mode, clear the accumulator and count, then go to RUN.
  - RUN: W cycles. Each cycle, if the current multiplier bit is 1, add the multiplicand into the upper part of the (2W+1)-bit accumulator. Then shift the accumulator right by 1 and increment count. When count reaches W-1, go to DONE.
  - DONE: one cycle. done=1; R1, R2 and Overflow are registered from the accumulator. Then go to IDLE.
- R1, R2 and Overflow hold their values until the next DONE or reset.
- Unsigned mode:
  - The product is the exact unsigned A*B.
  - Overflow = (R2 != 0).
- Signed mode:
  - Latch |A| and |B| as unsigned W-bit magnitudes; the most negative value maps to 2^(W-1).
  - Multiply the magnitudes unsigned.
  - Negate the 2W-bit result in DONE if sign(A) XOR sign(B).
  - Overflow = (R2 != {W{R1[W-1]}}).
- Boundaries:
  - start while ready=0 is ignored, with no effect on the operation in flight.
  - start held high continuously restarts on the first IDLE cycle.
  - Zero operands follow the full RUN length; there is no early termination.
  - Reset mid-operation aborts immediately. The next operation starts clean.

## Timing
- Start accepted at edge 0 → RUN occupies edges 1..W → DONE (done=1, outputs valid) in the cycle after edge W. Latency is W+1 cycles from accept to done.
- Throughput is one result per W+2 cycles. ready returns in the cycle after done.
- Reset values: ready=1, done=0, R1=0, R2=0, Overflow=0, state=IDLE, count=0.

## Configuration
- MUL_SIGNED_EN defined:
  - The signed_mode port exists.
  - The abs and negate logic is compiled in.
  - Signed Overflow is computed as above.
- MUL_SIGNED_EN undefined:
  - There is no signed_mode port.
  - All operations are unsigned.
  - The abs and negate logic is absent.

## Structure
- Package seq_mul_pkg holds:
  - the state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the counter-width function $clog2(W).
- One sub-module, seq_mul_adder: a W-bit adder with carry-out used for the accumulate step, instantiated once.

## Test plan
All vectors use W=3.
- Unsigned: A=2, B=3 → R1=6, R2=0, Overflow=0; done 4 cycles after accept.
- Unsigned: A=3, B=4 → R1=4, R2=1, Overflow=1. Also A=7, B=7 → R1=1, R2=6, Overflow=1.
- Signed (MUL_SIGNED_EN): A=7 (-1), B=7 (-1) → R1=1, R2=0, Overflow=0. Also A=4 (-4), B=7 (-1) → R1=4, R2=0, Overflow=1.
- Busy guard: run A=3, B=7; pulse start with A=1, B=1 during RUN → result R1=5, R2=2; exactly one done pulse.
- Reset mid-RUN:
  - Assert reset two cycles into A=7, B=7 → all outputs 0, ready=1 immediately.
  - Then run A=2, B=2 → R1=4, Overflow=0.
